seq_pattern_gen: RTL and testbench

//   Serial bit-pattern transmitter: on a start request, shifts a fixed PAT_W-bit

---
 rtl/seq_pattern_gen.sv | 133 +++++++++++++
 tb/tb_seq_pattern_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter. It shifts PATTERN out MSB-first, repeat_cnt times,
// and can insert an optional one-cycle idle gap between repetitions.
//   state  | meaning
//   IDLE   | waiting for start; outputs at idle level
//   SEND   | one pattern bit per cycle on dout, dout_valid=1
//   GAP    | single idle bit between repetitions, busy held
//   DONE   | one-cycle done pulse, then back to IDLE
module seq_pattern_gen #(
    parameter int               PAT_W      = 4,
    parameter logic [PAT_W-1:0] PATTERN    = 4'b1101,
    parameter int               CNT_W      = 4,
    parameter logic             IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             gap_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W   = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             gap_q, gap_d;
    logic             dout_d, valid_d, busy_d, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rep_q      <= '0;
            gap_q      <= 1'b0;
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rep_q      <= rep_d;
            gap_q      <= gap_d;
            dout       <= dout_d;
            dout_valid <= valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Outputs are computed for the upcoming state and registered with it.
    // rep_q holds the repetitions still owed after the current one.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        dout_d  = IDLE_LEVEL;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    gap_d = gap_en;
                    if (repeat_cnt != '0) begin
                        state_d = S_SEND;
                        idx_d   = IDX_MSB;
                        rep_d   = repeat_cnt - CNT_W'(1);
                        dout_d  = PATTERN[PAT_W-1];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        rep_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (idx_q != '0) begin
                    idx_d   = idx_q - IDX_W'(1);
                    dout_d  = PATTERN[idx_q - IDX_W'(1)];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    rep_d  = rep_q - CNT_W'(1);
                    busy_d = 1'b1;
                    if (gap_q) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_SEND;
                        idx_d   = IDX_MSB;
                        dout_d  = PATTERN[PAT_W-1];
                        valid_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                state_d = S_SEND;
                idx_d   = IDX_MSB;
                dout_d  = PATTERN[PAT_W-1];
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
                rep_d   = '0;
                gap_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: per-cycle checks of dout_valid/dout/busy/done
// against hand-computed sequences, with PATTERN=1101 and the default parameters.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] repeat_cnt;
    logic       gap_en;
    logic       dout, dout_valid, busy, done;

    int checks   = 0;
    int failures = 0;

    seq_pattern_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .repeat_cnt (repeat_cnt),
        .gap_en     (gap_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Drive start across one rising edge (edge t); returns in cycle t+1 at the negedge.
    task automatic do_start(input logic [3:0] cnt, input logic gap);
        @(negedge clk);
        start      = 1'b1;
        repeat_cnt = cnt;
        gap_en     = gap;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        repeat_cnt = 4'd0;
        gap_en     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat_cnt = 4'd0;
        gap_en = 1'b0;
        #12;
        checks++;
        if ({dout_valid, dout, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_initial: got v/d/b/dn=%b%b%b%b exp 0000", dout_valid, dout, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dout_valid, dout, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release: got v/d/b/dn=%b%b%b%b exp 0000", dout_valid, dout, busy, done);
        end
    endtask

    task automatic test_single();
        logic [5:0] ev = 6'b111100;
        logic [5:0] ed = 6'b110100;
        logic [5:0] eb = 6'b111100;
        logic [5:0] en = 6'b000010;
        do_start(4'd1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if ({dout_valid, dout, busy, done} !== {ev[5-k], ed[5-k], eb[5-k], en[5-k]}) begin
                failures++;
                $display("FAIL single cyc t+%0d: got v/d/b/dn=%b%b%b%b exp %b%b%b%b", k + 1,
                         dout_valid, dout, busy, done, ev[5-k], ed[5-k], eb[5-k], en[5-k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] ev = 14'b11111111111100;
        logic [13:0] ed = 14'b11011101110100;
        logic [13:0] eb = 14'b11111111111100;
        logic [13:0] en = 14'b00000000000010;
        logic [3:0]  sh = 4'b0000;
        int          hits = 0;
        do_start(4'd3, 1'b0);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            if (dout_valid) begin
                sh = {sh[2:0], dout};
                if (sh == 4'b1101) hits++;
            end
            checks++;
            if ({dout_valid, dout, busy, done} !== {ev[13-k], ed[13-k], eb[13-k], en[13-k]}) begin
                failures++;
                $display("FAIL b2b cyc t+%0d: got v/d/b/dn=%b%b%b%b exp %b%b%b%b", k + 1,
                         dout_valid, dout, busy, done, ev[13-k], ed[13-k], eb[13-k], en[13-k]);
            end
        end
        checks++;
        if (hits != 3) begin
            failures++;
            $display("FAIL b2b_detector_hits: got %0d exp 3", hits);
        end
    endtask

    task automatic test_gap();
        logic [10:0] ev = 11'b11110111100;
        logic [10:0] ed = 11'b11010110100;
        logic [10:0] eb = 11'b11111111100;
        logic [10:0] en = 11'b00000000010;
        do_start(4'd2, 1'b1);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if ({dout_valid, dout, busy, done} !== {ev[10-k], ed[10-k], eb[10-k], en[10-k]}) begin
                failures++;
                $display("FAIL gap cyc t+%0d: got v/d/b/dn=%b%b%b%b exp %b%b%b%b", k + 1,
                         dout_valid, dout, busy, done, ev[10-k], ed[10-k], eb[10-k], en[10-k]);
            end
        end
    endtask

    task automatic test_zero_and_ignore();
        logic [5:0] ev = 6'b111100;
        logic [5:0] ed = 6'b110100;
        logic [5:0] eb = 6'b111100;
        logic [5:0] en = 6'b000010;
        // Zero-length request with start held through the DONE cycle: done only once.
        @(negedge clk);
        start = 1'b1;
        repeat_cnt = 4'd0;
        gap_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dout_valid, dout, busy, done} !== 4'b0001) begin
            failures++;
            $display("FAIL zero_done: got v/d/b/dn=%b%b%b%b exp 0001", dout_valid, dout, busy, done);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({dout_valid, dout, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL zero_after: got v/d/b/dn=%b%b%b%b exp 0000", dout_valid, dout, busy, done);
        end
        // Start pulsed mid-transfer with different settings must not disturb the stream.
        do_start(4'd1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            start      = (k == 1);
            repeat_cnt = (k == 1) ? 4'd3 : 4'd0;
            gap_en     = (k == 1);
            checks++;
            if ({dout_valid, dout, busy, done} !== {ev[5-k], ed[5-k], eb[5-k], en[5-k]}) begin
                failures++;
                $display("FAIL ignore_start cyc t+%0d: got v/d/b/dn=%b%b%b%b exp %b%b%b%b", k + 1,
                         dout_valid, dout, busy, done, ev[5-k], ed[5-k], eb[5-k], en[5-k]);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [5:0] ev = 6'b111100;
        logic [5:0] ed = 6'b110100;
        logic [5:0] eb = 6'b111100;
        logic [5:0] en = 6'b000010;
        do_start(4'd2, 1'b0);
        @(negedge clk);
        checks++;
        if ({dout_valid, dout, busy} !== 3'b111) begin
            failures++;
            $display("FAIL mid_second_bit: got v/d/b=%b%b%b exp 111", dout_valid, dout, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({dout_valid, dout, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_async: got v/d/b/dn=%b%b%b%b exp 0000", dout_valid, dout, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({dout_valid, busy, done} !== 3'b000) begin
                failures++;
                $display("FAIL mid_post_reset cyc %0d: got v/b/dn=%b%b%b exp 000", k, dout_valid, busy, done);
            end
        end
        do_start(4'd1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if ({dout_valid, dout, busy, done} !== {ev[5-k], ed[5-k], eb[5-k], en[5-k]}) begin
                failures++;
                $display("FAIL restart cyc t+%0d: got v/d/b/dn=%b%b%b%b exp %b%b%b%b", k + 1,
                         dout_valid, dout, busy, done, ev[5-k], ed[5-k], eb[5-k], en[5-k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_zero_and_ignore();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
